// File: rtl/shifter_iterativ.sv
// Iterative SLL/SRA shifter: moves the operand one bit per clock under a
// Start/Done handshake, replacing a combinational barrel shifter.
`timescale 1ns/1ps

module shifter_iterativ #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   Shamt,
  input  logic             Drejtimi,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rezultati
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [SHW-1:0]   r_count;
  logic             r_mode;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  // DONE accepts too, so a new op can start back-to-back without an IDLE cycle.
  assign w_accept = Start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_mode  <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_data  <= A;
      r_count <= Shamt;
      r_mode  <= Drejtimi;
      r_state <= (Shamt != '0) ? S_SHIFT : S_DONE;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_mode) r_data <= {r_data[WIDTH-1], r_data[WIDTH-1:1]};
          else        r_data <= {r_data[WIDTH-2:0], 1'b0};
          r_count <= r_count - SHW'(1);
          if (r_count == SHW'(1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_IDLE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so no input reaches an output combinationally.
  assign Busy      = (r_state == S_SHIFT);
  assign Done      = (r_state == S_DONE);
  assign Rezultati = r_data;

endmodule
